mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: max consecutive non-ACCESS cycles allowed in a service state.
REQ-002 SHALL have port CLK  in  1  single system clock, rising-edge.
REQ-003 SHALL have port nRST  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port iREN  in  1  instruction-cache read request.
REQ-005 SHALL have port iaddr  in  32  instruction read address.
REQ-006 SHALL have port iwait  out  1  instruction stall; 0 marks completion.
REQ-007 SHALL have port iload  out  32  instruction read data.
REQ-008 SHALL have ports dREN/dWEN  in  1 each  data-cache read/write requests.
REQ-009 SHALL have ports daddr/dstore  in  32 each  data address/write data.
REQ-010 SHALL have ports dwait  out  1 and dload  out  32  data stall/read data.
REQ-011 SHALL have ports ramREN/ramWEN  out  1 each and ramaddr/ramstore  out  32 each  RAM request.
REQ-012 SHALL have ports ramload  in  32 and ramstate  in  2  RAM data and status (FREE=0, BUSY=1, ACCESS=2, ERROR=3).
REQ-013 SHALL have port memerr  out  1  sticky error flag.

Function
REQ-014 SHALL implement registered FSM with states IDLE, ISERV, DSERV, ERR.
REQ-015 IDLE: dREN|dWEN -> DSERV; else iREN -> ISERV; else stay; data SHALL beat instruction on simultaneous requests.
REQ-016 RAM outputs SHALL be driven combinationally from current state; request seen in cycle N reaches RAM in cycle N+1.
REQ-017 ISERV: ramREN=1, ramaddr=iaddr; ramWEN=0.
REQ-018 DSERV: dWEN=1 -> ramWEN=1, ramREN=0, ramstore=dstore; else ramREN=1; ramaddr=daddr; dWEN SHALL win if dREN and dWEN both set.
REQ-019 Completion SHALL be the cycle ramstate==ACCESS in a service state: served wait=0, served load=ramload (reads), next state IDLE.
REQ-020 Each completion SHALL be followed by exactly one IDLE cycle (no back-to-back grant; prevents double-service of a held request).
REQ-021 Unserved port SHALL keep wait=1 and load=0 at all times; idle outputs: waits 1, loads 0, RAM strobes 0, ramaddr/ramstore 0.
REQ-022 Served request withdrawn before ACCESS (ISERV with iREN=0, DSERV with dREN=dWEN=0): RAM strobes 0 that cycle, next state IDLE, no completion pulse.
REQ-023 Watchdog counter, width $clog2(TIMEOUT+1), SHALL clear on entering a service state and increment each service cycle without ACCESS.
REQ-024 ramstate==ERROR, or counter reaching TIMEOUT, in a service state SHALL move FSM to ERR next cycle.
REQ-025 ERR SHALL last one cycle: RAM strobes 0, the interrupted port gets wait=0 and load=32'hBAD0BAD0, memerr set; next state IDLE.
REQ-026 memerr SHALL remain 1 until reset.

Reset
REQ-027 nRST low SHALL immediately force IDLE, counter 0, memerr 0, all outputs to idle values (REQ-021), regardless of transaction in progress.
REQ-028 First request after reset release SHALL be arbitrated normally from IDLE.

Structure
REQ-029 ramstate_t enum SHALL live in cpu_types_pkg with word_t; FSM state enum SHALL be local to mem_responder.
REQ-030 Watchdog counter MAY be sub-module mem_watchdog (inputs clear, enable; output expired); all else in one module.

Verification
REQ-031 iREN=1, iaddr=0x40, ramstate BUSY x2 then ACCESS, ramload=0xDEADBEEF -> ramREN from cycle 1, iwait=0 with iload=0xDEADBEEF in cycle 3 only, IDLE cycle 4.
REQ-032 iREN and dREN raised same cycle, daddr=0x80 -> DSERV first, ramaddr=0x80; ISERV only after data completion plus one IDLE cycle; iwait=1 throughout data service.
REQ-033 dWEN=dREN=1, daddr=0x100, dstore=0x12345678 -> ramWEN=1, ramREN=0, ramstore=0x12345678; dwait=0 on ACCESS.
REQ-034 TIMEOUT=15, ramstate held BUSY in ISERV -> ERR after 15 service cycles, iwait=0 with iload=0xBAD0BAD0 once, memerr=1 persisting through later good transactions.
REQ-035 nRST asserted mid-DSERV -> same-instant ramWEN/ramREN=0, dwait=1, memerr=0; after release, pending dREN served from IDLE.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types.
//   word_t      : 32-bit machine word
//   ramstate_t  : RAM status reported back to the responder
//   BAD_WORD    : load value returned to a requestor whose access failed
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam word_t BAD_WORD = 32'hBAD0BAD0;

endpackage

// File: rtl/mem_watchdog.sv
// Watchdog for a single memory service.
//   CLK, nRST : clock, asynchronous active-low reset
//   clear     : hold count at zero (responder not in a service state)
//   enable    : a service cycle passed without ACCESS
//   expired   : this enabled cycle is the TIMEOUT-th consecutive one
module mem_watchdog #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST  = W'(TIMEOUT - 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

  logic [W-1:0] count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + W'(1);
    end
  end

  // Flag during the cycle in which the count reaches TIMEOUT so the FSM
  // lands in ERR on the following edge.
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_responder.sv
// Arbitrating memory responder between an instruction and a data cache.
//   CLK, nRST            : clock, asynchronous active-low reset
//   iREN, iaddr          : instruction read request / address
//   iwait, iload         : instruction stall (0 = done) / read data
//   dREN, dWEN           : data read / write request (write wins)
//   daddr, dstore        : data address / write data
//   dwait, dload         : data stall (0 = done) / read data
//   ramREN, ramWEN       : RAM strobes
//   ramaddr, ramstore    : RAM address / write data
//   ramload, ramstate    : RAM read data / status (FREE, BUSY, ACCESS, ERROR)
//   memerr               : sticky error flag, cleared only by reset
module mem_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISERV = 2'd1,
    DSERV = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t    state, state_next;
  logic      err_data, err_data_next;  // ERR belongs to the data port
  logic      memerr_q, memerr_next;
  logic      wd_clear, wd_enable, wd_expired;
  ramstate_t rs;
  logic      d_req;

  assign rs     = ramstate_t'(ramstate);
  assign d_req  = dREN | dWEN;
  assign memerr = memerr_q;

  // Counter restarts every time a service state is entered from IDLE.
  assign wd_clear = !((state == ISERV) || (state == DSERV));

  mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .CLK     (CLK),
    .nRST    (nRST),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      err_data <= 1'b0;
      memerr_q <= 1'b0;
    end else begin
      state    <= state_next;
      err_data <= err_data_next;
      memerr_q <= memerr_next;
    end
  end

  always_comb begin
    state_next    = state;
    err_data_next = err_data;
    memerr_next   = memerr_q;
    wd_enable     = 1'b0;
    iwait         = 1'b1;
    iload         = '0;
    dwait         = 1'b1;
    dload         = '0;
    ramREN        = 1'b0;
    ramWEN        = 1'b0;
    ramaddr       = '0;
    ramstore      = '0;

    unique case (state)
      IDLE: begin
        if (d_req) begin
          state_next = DSERV;
        end else if (iREN) begin
          state_next = ISERV;
        end
      end

      ISERV: begin
        if (!iREN) begin
          // Request withdrawn: drop the RAM access without completing.
          state_next = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (rs == ACCESS) begin
            iwait      = 1'b0;
            iload      = ramload;
            state_next = IDLE;
          end else begin
            wd_enable = 1'b1;
            if ((rs == ERROR) || wd_expired) begin
              state_next    = ERR;
              err_data_next = 1'b0;
            end
          end
        end
      end

      DSERV: begin
        if (!d_req) begin
          state_next = IDLE;
        end else begin
          ramaddr = daddr;
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          if (rs == ACCESS) begin
            dwait      = 1'b0;
            dload      = dWEN ? '0 : ramload;
            state_next = IDLE;
          end else begin
            wd_enable = 1'b1;
            if ((rs == ERROR) || wd_expired) begin
              state_next    = ERR;
              err_data_next = 1'b1;
            end
          end
        end
      end

      ERR: begin
        if (err_data) begin
          dwait = 1'b0;
          dload = BAD_WORD;
        end else begin
          iwait = 1'b0;
          iload = BAD_WORD;
        end
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase

    if (state_next == ERR) begin
      memerr_next = 1'b1;
    end
  end

endmodule
